// File: rtl/uartprobe_axi_pkg.sv
// Shared response codes, size encoding and FSM state types for the uartprobe AXI responder.
package uartprobe_axi_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] SIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      WR_IDLE, WR_WAIT_W, WR_WAIT_AW, WR_DELAY, WR_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      RD_IDLE, RD_DELAY, RD_DATA
   } rd_state_t;
endpackage

// File: rtl/uartprobe_axi_responder_if.sv
// AXI4 single-beat port subset shared by the uartprobe master and this responder.
interface uartprobe_axi_responder_if;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arready;
   logic [2:0]  s_axi_arsize;
   logic        s_axi_arvalid;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awready;
   logic [2:0]  s_axi_awsize;
   logic        s_axi_awvalid;
   logic        s_axi_bready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic [31:0] s_axi_rdata;
   logic        s_axi_rlast;
   logic        s_axi_rready;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic [31:0] s_axi_wdata;
   logic        s_axi_wlast;
   logic        s_axi_wready;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;

   modport master (
      output s_axi_araddr, s_axi_arsize, s_axi_arvalid, s_axi_awaddr, s_axi_awsize,
             s_axi_awvalid, s_axi_bready, s_axi_rready, s_axi_wdata, s_axi_wlast,
             s_axi_wstrb, s_axi_wvalid,
      input  s_axi_arready, s_axi_awready, s_axi_bresp, s_axi_bvalid, s_axi_rdata,
             s_axi_rlast, s_axi_rresp, s_axi_rvalid, s_axi_wready
   );

   modport slave (
      input  s_axi_araddr, s_axi_arsize, s_axi_arvalid, s_axi_awaddr, s_axi_awsize,
             s_axi_awvalid, s_axi_bready, s_axi_rready, s_axi_wdata, s_axi_wlast,
             s_axi_wstrb, s_axi_wvalid,
      output s_axi_arready, s_axi_awready, s_axi_bresp, s_axi_bvalid, s_axi_rdata,
             s_axi_rlast, s_axi_rresp, s_axi_rvalid, s_axi_wready
   );
endinterface

// File: rtl/uartprobe_axi_decode.sv
// Address/size decode for one AXI channel: word index plus OKAY/SLVERR/DECERR.
module uartprobe_axi_decode
   import uartprobe_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          DEPTH     = 16
) (
   input  logic [31:0]              addr,
   input  logic [2:0]               size,
   output logic [$clog2(DEPTH)-1:0] idx,
   output logic [1:0]               resp
);
   localparam int IDX_W = $clog2(DEPTH);

   assign idx = addr[IDX_W+1:2];

   // BASE_ADDR is window-aligned, so the range test is an upper-bit compare
   always_comb begin
      if (addr[31:IDX_W+2] != BASE_ADDR[31:IDX_W+2])
         resp = RESP_DECERR;
      else if (addr[1:0] != 2'b00 || size > SIZE_WORD)
         resp = RESP_SLVERR;
      else
         resp = RESP_OKAY;
   end
endmodule

// File: rtl/uartprobe_axi_responder.sv
// AXI4 single-beat register-memory slave; independent read/write FSMs, one outstanding each.
// Optional UARTPROBE_AXI_RESP_DELAY_EN adds RESP_DELAY extra cycles before bvalid/rvalid.
module uartprobe_axi_responder
   import uartprobe_axi_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          DEPTH      = 16,
   parameter int          RESP_DELAY = 4
) (
   input logic clk,
   input logic areset,
   uartprobe_axi_responder_if.slave axi
);
   localparam int IDX_W = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RESP_DELAY < 0 ||
       (BASE_ADDR % (DEPTH * 4)) != 0) begin : g_bad_cfg
      $error("uartprobe_axi_responder: invalid BASE_ADDR/DEPTH/RESP_DELAY");
   end

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   logic [DEPTH-1:0][31:0] mem;

   logic             aw_hs, w_hs, ar_hs, wr_done;
   logic [31:0]      aw_addr_q, w_data_q, aw_addr, w_data;
   logic [2:0]       aw_size_q, aw_size;
   logic [3:0]       w_strb_q, w_strb;
   logic             w_last_q, w_last;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [1:0]       wr_dec, wr_resp, rd_dec;
   logic [1:0]       bresp_q, rresp_q;
   logic [31:0]      rdata_q;

   assign aw_hs = axi.s_axi_awvalid & axi.s_axi_awready;
   assign w_hs  = axi.s_axi_wvalid  & axi.s_axi_wready;
   assign ar_hs = axi.s_axi_arvalid & axi.s_axi_arready;
   // the write completes when the last of AW/W lands, either alone or together
   assign wr_done = (aw_hs | (wr_state == WR_WAIT_W)) & (w_hs | (wr_state == WR_WAIT_AW));

`ifdef UARTPROBE_AXI_RESP_DELAY_EN
   localparam wr_state_t   WR_FIRST = (RESP_DELAY == 0) ? WR_RESP : WR_DELAY;
   localparam rd_state_t   RD_FIRST = (RESP_DELAY == 0) ? RD_DATA : RD_DELAY;
   localparam logic [15:0] DLY      = 16'(RESP_DELAY);
   logic [15:0] wr_cnt, rd_cnt;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (wr_done)                                  wr_cnt <= DLY;
         else if (wr_state == WR_DELAY && wr_cnt != 0) wr_cnt <= wr_cnt - 16'd1;
         if (ar_hs)                                    rd_cnt <= DLY;
         else if (rd_state == RD_DELAY && rd_cnt != 0) rd_cnt <= rd_cnt - 16'd1;
      end
   end
`else
   localparam wr_state_t WR_FIRST = WR_RESP;
   localparam rd_state_t RD_FIRST = RD_DATA;
`endif

   always_comb begin
      aw_addr = aw_hs ? axi.s_axi_awaddr : aw_addr_q;
      aw_size = aw_hs ? axi.s_axi_awsize : aw_size_q;
      w_data  = w_hs  ? axi.s_axi_wdata  : w_data_q;
      w_strb  = w_hs  ? axi.s_axi_wstrb  : w_strb_q;
      w_last  = w_hs  ? axi.s_axi_wlast  : w_last_q;
   end

   uartprobe_axi_decode #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) u_wr_dec (
      .addr(aw_addr), .size(aw_size), .idx(wr_idx), .resp(wr_dec)
   );

   uartprobe_axi_decode #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH)) u_rd_dec (
      .addr(axi.s_axi_araddr), .size(axi.s_axi_arsize), .idx(rd_idx), .resp(rd_dec)
   );

   assign wr_resp = (wr_dec == RESP_OKAY && !w_last) ? RESP_SLVERR : wr_dec;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_state <= WR_IDLE;
         rd_state <= RD_IDLE;
      end else begin
         wr_state <= wr_next;
         rd_state <= rd_next;
      end
   end

   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         WR_IDLE: begin
            if (aw_hs && w_hs) wr_next = WR_FIRST;
            else if (aw_hs)    wr_next = WR_WAIT_W;
            else if (w_hs)     wr_next = WR_WAIT_AW;
         end
         WR_WAIT_W:  if (w_hs)  wr_next = WR_FIRST;
         WR_WAIT_AW: if (aw_hs) wr_next = WR_FIRST;
`ifdef UARTPROBE_AXI_RESP_DELAY_EN
         WR_DELAY:   if (wr_cnt <= 16'd1) wr_next = WR_RESP;
`endif
         WR_RESP:    if (axi.s_axi_bready) wr_next = WR_IDLE;
         default:    wr_next = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         RD_IDLE:  if (ar_hs) rd_next = RD_FIRST;
`ifdef UARTPROBE_AXI_RESP_DELAY_EN
         RD_DELAY: if (rd_cnt <= 16'd1) rd_next = RD_DATA;
`endif
         RD_DATA:  if (axi.s_axi_rready) rd_next = RD_IDLE;
         default:  rd_next = RD_IDLE;
      endcase
   end

   // readies are gated by reset so nothing is accepted while areset is high
   always_comb begin
      axi.s_axi_awready = !areset && (wr_state == WR_IDLE || wr_state == WR_WAIT_AW);
      axi.s_axi_wready  = !areset && (wr_state == WR_IDLE || wr_state == WR_WAIT_W);
      axi.s_axi_bvalid  = (wr_state == WR_RESP);
      axi.s_axi_bresp   = bresp_q;
      axi.s_axi_arready = !areset && (rd_state == RD_IDLE);
      axi.s_axi_rvalid  = (rd_state == RD_DATA);
      axi.s_axi_rlast   = (rd_state == RD_DATA);
      axi.s_axi_rresp   = rresp_q;
      axi.s_axi_rdata   = rdata_q;
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         aw_addr_q <= '0;
         aw_size_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         w_last_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_addr_q <= axi.s_axi_awaddr;
            aw_size_q <= axi.s_axi_awsize;
         end
         if (w_hs) begin
            w_data_q <= axi.s_axi_wdata;
            w_strb_q <= axi.s_axi_wstrb;
            w_last_q <= axi.s_axi_wlast;
         end
         if (wr_done) bresp_q <= wr_resp;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         mem <= '0;
      end else if (wr_done && wr_resp == RESP_OKAY) begin
         for (int b = 0; b < 4; b++)
            if (w_strb[b]) mem[wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
      end
   end

   // read samples mem before a same-edge commit lands, giving the pre-write value
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (ar_hs) begin
         rdata_q <= (rd_dec == RESP_OKAY) ? mem[rd_idx] : 32'h0;
         rresp_q <= rd_dec;
      end
   end
endmodule

// File: doc/uartprobe_axi_responder.md
Name: uartprobe_axi_responder

Overview:
- AXI4 single-beat slave with a small register memory; it is the responder end of the uartprobe AXI master port.
- Its port subset matches the probe master port exactly, so the probe, or any master in the same codebase, can be tested end to end without vendor IP.
- Read and write channels run independently; at most one transaction is outstanding per channel.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned.
- DEPTH, 16, number of 32-bit words; a power of two, minimum 2.
- RESP_DELAY, 4, extra response cycles; used only when UARTPROBE_AXI_RESP_DELAY_EN is defined.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_axi_araddr  in  32  read address.
- s_axi_arready  out  1  read address accept.
- s_axi_arsize  in  3  read size.
- s_axi_arvalid  in  1  read address valid.
- s_axi_awaddr  in  32  write address.
- s_axi_awready  out  1  write address accept.
- s_axi_awsize  in  3  write size.
- s_axi_awvalid  in  1  write address valid.
- s_axi_bready  in  1  write response accept.
- s_axi_bresp  out  2  write response code.
- s_axi_bvalid  out  1  write response valid.
- s_axi_rdata  out  32  read data.
- s_axi_rlast  out  1  last read beat; always 1 while rvalid=1.
- s_axi_rready  in  1  read data accept.
- s_axi_rresp  out  2  read response code.
- s_axi_rvalid  out  1  read data valid.
- s_axi_wdata  in  32  write data.
- s_axi_wlast  in  1  last write beat.
- s_axi_wready  out  1  write data accept.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid  in  1  write data valid.

Behaviour:
- Reset (areset=1, async):
  - All ready/valid outputs go to 0; bresp, rresp, rdata and rlast go to 0.
  - All memory words clear to 0; both FSMs enter IDLE.
  - A transaction in flight is dropped; no response is issued after release.
- Decode (per address):
  - Index = addr[IDX_W+1:2], where IDX_W = clog2(DEPTH).
  - Address outside [BASE_ADDR, BASE_ADDR+DEPTH*4) -> DECERR (2'b11).
  - Otherwise, addr[1:0] != 0 or size > 3'b010 -> SLVERR (2'b10).
  - Otherwise -> OKAY (2'b00).
  - Sizes below 3'b010 are accepted; wstrb alone selects the bytes written.
- Write FSM:
  - WR_IDLE: awready=1 and wready=1. AW and W are captured independently on their handshakes.
    - Both in the same cycle -> WR_RESP.
    - AW only -> WR_WAIT_W (awready=0, wready=1).
    - W only -> WR_WAIT_AW (awready=1, wready=0).
  - WR_WAIT_W / WR_WAIT_AW: the missing handshake -> WR_RESP.
  - On the edge entering WR_RESP, the memory commits if the response is OKAY: byte i updates iff wstrb[i].
  - wlast=0 -> SLVERR, no commit.
  - WR_RESP: bvalid=1, both readies 0; bresp is held stable until bready -> WR_IDLE.
  - Minimum latency: AW+W handshake at edge N -> bvalid high after edge N.
  - Back-to-back throughput: one write per 2 cycles.
- Read FSM:
  - RD_IDLE: arready=1. The handshake samples memory and decode into the rdata/rresp registers -> RD_DATA.
  - RD_DATA: rvalid=1, rlast=1, arready=0; rdata and rresp are held until rready -> RD_IDLE.
  - Error responses return rdata=0.
  - Minimum latency: 1 cycle from AR handshake to rvalid.
- Collision: if an AR handshake and a write commit land on the same edge and address, the read returns the pre-write value.
- Master-side stalls: bready or rready held low indefinitely holds the response stable with no timeout. The other channel keeps operating.

Optional Feature:
- Macro: UARTPROBE_AXI_RESP_DELAY_EN.
- Defined:
  - Adds a WR_DELAY state before WR_RESP and an RD_DELAY state before RD_DATA.
  - Each channel has a down-counter loaded with RESP_DELAY; bvalid/rvalid assert RESP_DELAY cycles later than baseline.
  - Memory commit and read sampling keep their baseline timing.
  - RESP_DELAY=0 is identical to baseline.
- Undefined: no counters or delay states; RESP_DELAY is ignored.

Decomposition:
- Package uartprobe_axi_pkg:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR codes.
  - SIZE_WORD=3'b010.
  - Write-FSM and read-FSM state encodings.
- Sub-module uartprobe_axi_decode: combinational address/size check returning index and resp; instantiated once per channel.

Test Plan:
- Reset, then write 32'hDEADBEEF to BASE+8 with wstrb=4'hF, AW and W in the same cycle -> bvalid next cycle, bresp=00. Read BASE+8 -> rvalid 1 cycle after AR, rdata=DEADBEEF, rlast=1.
- W two cycles before AW, wstrb=4'b0101, wdata=32'h11223344 over DEADBEEF -> bresp=00; read-back gives 32'hDE22BE44.
- AW to BASE+DEPTH*4 -> bresp=11, no memory change. araddr=BASE+2 -> rresp=10, rdata=0. arsize=3'b011 -> rresp=10.
- Hold bready=0 for 10 cycles -> bvalid and bresp stable, awready=0. Meanwhile a read completes normally.
- AR handshake on the same edge as a write commit to the same address (old 0, new 5) -> rdata=0. A following read gives 5.
- Assert areset while RD_DATA is pending -> rvalid drops immediately; memory reads 0 after release. With the macro defined and RESP_DELAY=4 -> bvalid asserts 5 cycles after the handshake.
